mem_burst_arbiter: RTL and testbench

- Shares one external memory controller user port (mem_clk domain) between two frame_read_write clients: client 0 is the camera path, client 1 is the display/conv path.
- Each client owns one burst-read and one burst-write master, giving 4 requesters arbitrated round-robin.
- The winner's burst request, length and address go to the controller. Data-valid, data-request and finish strobes are steered back to that winner only.
- The block sits between the frame_read_write instances and the DDR controller wrapper.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/rr_pick4.sv | 29 ++
 rtl/mem_burst_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_burst_arbiter.sv | 595 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory burst arbiter: FSM encoding,
// requester numbering and helpers that decode a requester index.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BUSY = 2'd1,
        WR_BUSY = 2'd2
    } arb_state_t;

    localparam int NUM_REQ = 4;

    localparam logic [1:0] REQ_C0_RD = 2'd0;
    localparam logic [1:0] REQ_C0_WR = 2'd1;
    localparam logic [1:0] REQ_C1_RD = 2'd2;
    localparam logic [1:0] REQ_C1_WR = 2'd3;

    // Odd requester indices are write masters, the upper bit names the client.
    function automatic logic req_is_write(input logic [1:0] id);
        return id[0];
    endfunction

    function automatic logic req_client(input logic [1:0] id);
        return id[1];
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set request at or above ptr,
// wrapping from index 3 back to 0.
module rr_pick4
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [1:0]         gnt_id,
    output logic               gnt_valid
);

    // Rotate so that rot[0] is the requester at ptr; lowest set bit then wins.
    logic [NUM_REQ-1:0] rot;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        assign rot[gi] = req[ptr + 2'(gi)];
    end

    always_comb begin
        gnt_id    = 2'd0;
        gnt_valid = |rot;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_id = ptr + 2'(k);
            end
        end
    end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Shares one memory controller user port between two frame_read_write clients,
// each with a burst-read and a burst-write master, using round-robin arbitration.
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 24,
    parameter int BUSRT_BITS    = 10,
    parameter int NUM_CLIENTS   = 2
) (
    input  logic                               mem_clk,
    input  logic                               rst,
    input  logic [NUM_CLIENTS-1:0]             c_rd_burst_req,
    input  logic [NUM_CLIENTS*BUSRT_BITS-1:0]  c_rd_burst_len,
    input  logic [NUM_CLIENTS*ADDR_BITS-1:0]   c_rd_burst_addr,
    output logic [NUM_CLIENTS-1:0]             c_rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0]           c_rd_burst_data,
    output logic [NUM_CLIENTS-1:0]             c_rd_burst_finish,
    input  logic [NUM_CLIENTS-1:0]             c_wr_burst_req,
    input  logic [NUM_CLIENTS*BUSRT_BITS-1:0]  c_wr_burst_len,
    input  logic [NUM_CLIENTS*ADDR_BITS-1:0]   c_wr_burst_addr,
    output logic [NUM_CLIENTS-1:0]             c_wr_burst_data_req,
    input  logic [NUM_CLIENTS*MEM_DATA_BITS-1:0] c_wr_burst_data,
    output logic [NUM_CLIENTS-1:0]             c_wr_burst_finish,
    output logic                               rd_burst_req,
    output logic [BUSRT_BITS-1:0]              rd_burst_len,
    output logic [ADDR_BITS-1:0]               rd_burst_addr,
    input  logic                               rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0]           rd_burst_data,
    input  logic                               rd_burst_finish,
    output logic                               wr_burst_req,
    output logic [BUSRT_BITS-1:0]              wr_burst_len,
    output logic [ADDR_BITS-1:0]               wr_burst_addr,
    input  logic                               wr_burst_data_req,
    input  logic                               wr_burst_finish,
    output logic [MEM_DATA_BITS-1:0]           wr_burst_data,
    output logic [1:0]                         grant_id,
    output logic                               busy
);

    arb_state_t             state_reg, state_next;
    logic [1:0]             rr_ptr_reg, rr_ptr_next;
    logic [1:0]             grant_id_reg, grant_id_next;
    logic                   rd_req_reg, rd_req_next;
    logic                   wr_req_reg, wr_req_next;
    logic                   busy_reg, busy_next;
    logic [BUSRT_BITS-1:0]  rd_len_reg, rd_len_next;
    logic [BUSRT_BITS-1:0]  wr_len_reg, wr_len_next;
    logic [ADDR_BITS-1:0]   rd_addr_reg, rd_addr_next;
    logic [ADDR_BITS-1:0]   wr_addr_reg, wr_addr_next;

    logic [NUM_REQ-1:0]     req_vec;
    logic [1:0]             pick_id;
    logic                   pick_valid;
    logic                   pick_client;

    assign req_vec[REQ_C0_RD] = c_rd_burst_req[0];
    assign req_vec[REQ_C0_WR] = c_wr_burst_req[0];
    assign req_vec[REQ_C1_RD] = c_rd_burst_req[1];
    assign req_vec[REQ_C1_WR] = c_wr_burst_req[1];

    rr_pick4 u_pick (
        .req       (req_vec),
        .ptr       (rr_ptr_reg),
        .gnt_id    (pick_id),
        .gnt_valid (pick_valid)
    );

    assign pick_client = req_client(pick_id);

    // Grants are only issued from IDLE, so a finished burst always leaves one
    // IDLE cycle in which its client can drop a registered request.
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        grant_id_next = grant_id_reg;
        rd_req_next   = rd_req_reg;
        wr_req_next   = wr_req_reg;
        busy_next     = busy_reg;
        rd_len_next   = rd_len_reg;
        wr_len_next   = wr_len_reg;
        rd_addr_next  = rd_addr_reg;
        wr_addr_next  = wr_addr_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_id_next = pick_id;
                    rr_ptr_next   = pick_id + 2'd1;
                    busy_next     = 1'b1;
                    if (req_is_write(pick_id)) begin
                        wr_req_next  = 1'b1;
                        wr_len_next  = c_wr_burst_len[pick_client*BUSRT_BITS +: BUSRT_BITS];
                        wr_addr_next = c_wr_burst_addr[pick_client*ADDR_BITS +: ADDR_BITS];
                        state_next   = WR_BUSY;
                    end else begin
                        rd_req_next  = 1'b1;
                        rd_len_next  = c_rd_burst_len[pick_client*BUSRT_BITS +: BUSRT_BITS];
                        rd_addr_next = c_rd_burst_addr[pick_client*ADDR_BITS +: ADDR_BITS];
                        state_next   = RD_BUSY;
                    end
                end
            end
            RD_BUSY: begin
                if (rd_burst_finish) begin
                    rd_req_next = 1'b0;
                    busy_next   = 1'b0;
                    state_next  = IDLE;
                end
            end
            WR_BUSY: begin
                if (wr_burst_finish) begin
                    wr_req_next = 1'b0;
                    busy_next   = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= 2'd0;
            grant_id_reg <= 2'd0;
            rd_req_reg   <= 1'b0;
            wr_req_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            rd_len_reg   <= '0;
            wr_len_reg   <= '0;
            rd_addr_reg  <= '0;
            wr_addr_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            grant_id_reg <= grant_id_next;
            rd_req_reg   <= rd_req_next;
            wr_req_reg   <= wr_req_next;
            busy_reg     <= busy_next;
            rd_len_reg   <= rd_len_next;
            wr_len_reg   <= wr_len_next;
            rd_addr_reg  <= rd_addr_next;
            wr_addr_reg  <= wr_addr_next;
        end
    end

    logic owner_client;
    logic rd_active;
    logic wr_active;

    assign owner_client = req_client(grant_id_reg);
    assign rd_active    = (state_reg == RD_BUSY);
    assign wr_active    = (state_reg == WR_BUSY);

    // Controller strobes reach only the owning client, and only while the
    // burst type matches the current busy state.
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_steer
        logic is_owner;
        assign is_owner                  = (owner_client == 1'(gi));
        assign c_rd_burst_data_valid[gi] = rd_active && is_owner && rd_burst_data_valid;
        assign c_rd_burst_finish[gi]     = rd_active && is_owner && rd_burst_finish;
        assign c_wr_burst_data_req[gi]   = wr_active && is_owner && wr_burst_data_req;
        assign c_wr_burst_finish[gi]     = wr_active && is_owner && wr_burst_finish;
    end

    assign wr_burst_data   = wr_active ? c_wr_burst_data[owner_client*MEM_DATA_BITS +: MEM_DATA_BITS]
                                       : c_wr_burst_data[0 +: MEM_DATA_BITS];
    assign c_rd_burst_data = rd_burst_data;

    assign rd_burst_req  = rd_req_reg;
    assign rd_burst_len  = rd_len_reg;
    assign rd_burst_addr = rd_addr_reg;
    assign wr_burst_req  = wr_req_reg;
    assign wr_burst_len  = wr_len_reg;
    assign wr_burst_addr = wr_addr_reg;
    assign grant_id      = grant_id_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Self-checking bench for mem_burst_arbiter: a behavioural controller/client
// model drives bursts and predicts grant order from the round-robin rule.
module tb_mem_burst_arbiter;

    localparam int MDB = 64;
    localparam int AB  = 24;
    localparam int BB  = 10;

    logic              mem_clk;
    logic              rst;
    logic [1:0]        c_rd_burst_req;
    logic [2*BB-1:0]   c_rd_burst_len;
    logic [2*AB-1:0]   c_rd_burst_addr;
    logic [1:0]        c_rd_burst_data_valid;
    logic [MDB-1:0]    c_rd_burst_data;
    logic [1:0]        c_rd_burst_finish;
    logic [1:0]        c_wr_burst_req;
    logic [2*BB-1:0]   c_wr_burst_len;
    logic [2*AB-1:0]   c_wr_burst_addr;
    logic [1:0]        c_wr_burst_data_req;
    logic [2*MDB-1:0]  c_wr_burst_data;
    logic [1:0]        c_wr_burst_finish;
    logic              rd_burst_req;
    logic [BB-1:0]     rd_burst_len;
    logic [AB-1:0]     rd_burst_addr;
    logic              rd_burst_data_valid;
    logic [MDB-1:0]    rd_burst_data;
    logic              rd_burst_finish;
    logic              wr_burst_req;
    logic [BB-1:0]     wr_burst_len;
    logic [AB-1:0]     wr_burst_addr;
    logic              wr_burst_data_req;
    logic              wr_burst_finish;
    logic [MDB-1:0]    wr_burst_data;
    logic [1:0]        grant_id;
    logic              busy;

    mem_burst_arbiter #(
        .MEM_DATA_BITS (MDB),
        .ADDR_BITS     (AB),
        .BUSRT_BITS    (BB),
        .NUM_CLIENTS   (2)
    ) dut (
        .mem_clk               (mem_clk),
        .rst                   (rst),
        .c_rd_burst_req        (c_rd_burst_req),
        .c_rd_burst_len        (c_rd_burst_len),
        .c_rd_burst_addr       (c_rd_burst_addr),
        .c_rd_burst_data_valid (c_rd_burst_data_valid),
        .c_rd_burst_data       (c_rd_burst_data),
        .c_rd_burst_finish     (c_rd_burst_finish),
        .c_wr_burst_req        (c_wr_burst_req),
        .c_wr_burst_len        (c_wr_burst_len),
        .c_wr_burst_addr       (c_wr_burst_addr),
        .c_wr_burst_data_req   (c_wr_burst_data_req),
        .c_wr_burst_data       (c_wr_burst_data),
        .c_wr_burst_finish     (c_wr_burst_finish),
        .rd_burst_req          (rd_burst_req),
        .rd_burst_len          (rd_burst_len),
        .rd_burst_addr         (rd_burst_addr),
        .rd_burst_data_valid   (rd_burst_data_valid),
        .rd_burst_data         (rd_burst_data),
        .rd_burst_finish       (rd_burst_finish),
        .wr_burst_req          (wr_burst_req),
        .wr_burst_len          (wr_burst_len),
        .wr_burst_addr         (wr_burst_addr),
        .wr_burst_data_req     (wr_burst_data_req),
        .wr_burst_finish       (wr_burst_finish),
        .wr_burst_data         (wr_burst_data),
        .grant_id              (grant_id),
        .busy                  (busy)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    int checks   = 0;
    int failures = 0;

    // Pending requests per requester index (0 c0 rd, 1 c0 wr, 2 c1 rd, 3 c1 wr).
    bit [3:0]      pend;
    logic [BB-1:0] req_len [4];
    logic [AB-1:0] req_addr[4];
    int            ptr_m;

    function automatic int pick(input bit [3:0] p, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (p[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic int lowest(input bit [3:0] p);
        for (int k = 0; k < 4; k++) begin
            if (p[k]) return k;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic drive_reqs();
        c_rd_burst_req[0]        = pend[0];
        c_wr_burst_req[0]        = pend[1];
        c_rd_burst_req[1]        = pend[2];
        c_wr_burst_req[1]        = pend[3];
        c_rd_burst_len[0 +: BB]  = req_len[0];
        c_wr_burst_len[0 +: BB]  = req_len[1];
        c_rd_burst_len[BB +: BB] = req_len[2];
        c_wr_burst_len[BB +: BB] = req_len[3];
        c_rd_burst_addr[0 +: AB]  = req_addr[0];
        c_wr_burst_addr[0 +: AB]  = req_addr[1];
        c_rd_burst_addr[AB +: AB] = req_addr[2];
        c_wr_burst_addr[AB +: AB] = req_addr[3];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pend = 4'b0;
        for (int k = 0; k < 4; k++) begin
            req_len[k]  = '0;
            req_addr[k] = '0;
        end
        drive_reqs();
        rd_burst_data_valid = 1'b0;
        rd_burst_data       = '0;
        rd_burst_finish     = 1'b0;
        wr_burst_data_req   = 1'b0;
        wr_burst_finish     = 1'b0;
        c_wr_burst_data     = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic await_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rd_burst_req || wr_burst_req) begin
                got = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // Plays the controller for one burst of the given requester; returns
    // counts of steered strobes seen at the owning client and at the other.
    task automatic serve(input int idx, input int beats, output int own_cnt,
                         output int other_cnt, output int data_err, output bit fin_ok);
        int own;
        own       = idx / 2;
        own_cnt   = 0;
        other_cnt = 0;
        data_err  = 0;
        for (int b = 0; b < beats; b++) begin
            if (idx % 2 == 0) begin
                rd_burst_data_valid = 1'b1;
                rd_burst_data       = {$urandom, $urandom};
            end else begin
                wr_burst_data_req = 1'b1;
                c_wr_burst_data   = {$urandom, $urandom, $urandom, $urandom};
            end
            #1;
            if (idx % 2 == 0) begin
                if (c_rd_burst_data_valid[own])     own_cnt++;
                if (c_rd_burst_data_valid[1 - own]) other_cnt++;
                if (c_rd_burst_data !== rd_burst_data) data_err++;
            end else begin
                if (c_wr_burst_data_req[own])     own_cnt++;
                if (c_wr_burst_data_req[1 - own]) other_cnt++;
                if (wr_burst_data !== c_wr_burst_data[own*MDB +: MDB]) data_err++;
            end
            tick();
            rd_burst_data_valid = 1'b0;
            wr_burst_data_req   = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        if (idx % 2 == 0) rd_burst_finish = 1'b1;
        else              wr_burst_finish = 1'b1;
        #1;
        if (idx % 2 == 0) fin_ok = (c_rd_burst_finish === (2'b01 << own)) && (c_wr_burst_finish === 2'b00);
        else              fin_ok = (c_wr_burst_finish === (2'b01 << own)) && (c_rd_burst_finish === 2'b00);
        tick();
        rd_burst_finish = 1'b0;
        wr_burst_finish = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pend = 4'b0;
        for (int k = 0; k < 4; k++) begin
            req_len[k]  = '0;
            req_addr[k] = '0;
        end
        drive_reqs();
        rd_burst_data_valid = 1'b0;
        rd_burst_data       = '0;
        rd_burst_finish     = 1'b0;
        wr_burst_data_req   = 1'b0;
        wr_burst_finish     = 1'b0;
        c_wr_burst_data     = '0;
        tick();
        tick();
        $display("reset: grant=%0d busy=%0b rd_req=%0b wr_req=%0b", grant_id, busy, rd_burst_req, wr_burst_req);
        checks++;
        if ({grant_id, busy, rd_burst_req, wr_burst_req} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got grant=%0d busy=%0b rd=%0b wr=%0b want all 0", grant_id, busy, rd_burst_req, wr_burst_req);
        end
        checks++;
        if ({rd_burst_len, rd_burst_addr, wr_burst_len, wr_burst_addr} !== '0) begin
            failures++;
            $display("FAIL reset_latch got rd %0d/%h wr %0d/%h want 0", rd_burst_len, rd_burst_addr, wr_burst_len, wr_burst_addr);
        end
        rd_burst_data_valid = 1'b1;
        rd_burst_finish     = 1'b1;
        wr_burst_data_req   = 1'b1;
        wr_burst_finish     = 1'b1;
        #1;
        checks++;
        if ({c_rd_burst_data_valid, c_rd_burst_finish, c_wr_burst_data_req, c_wr_burst_finish} !== 8'b0) begin
            failures++;
            $display("FAIL reset_steer got %b %b %b %b want all 0", c_rd_burst_data_valid, c_rd_burst_finish, c_wr_burst_data_req, c_wr_burst_finish);
        end
        rd_burst_data_valid = 1'b0;
        rd_burst_finish     = 1'b0;
        wr_burst_data_req   = 1'b0;
        wr_burst_finish     = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || rd_burst_req !== 1'b0 || wr_burst_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%0b rd=%0b wr=%0b want 0 with no requests", busy, rd_burst_req, wr_burst_req);
        end
    endtask

    task automatic test_round_robin();
        bit got;
        int oc, xc, de;
        bit fo;
        do_reset();
        pend = 4'hF;
        for (int k = 0; k < 4; k++) begin
            req_len[k]  = BB'(16);
            req_addr[k] = AB'($urandom);
        end
        drive_reqs();
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (!(rd_burst_req || wr_burst_req)) begin
                failures++;
                $display("FAIL rr_latency burst=%0d got no request want request 1 cycle after IDLE", n);
                await_req(got);
                if (!got) return;
            end
            $display("rr burst %0d: grant=%0d rd=%0b wr=%0b", n, grant_id, rd_burst_req, wr_burst_req);
            checks++;
            if (grant_id !== 2'(n % 4)) begin
                failures++;
                $display("FAIL rr_order burst=%0d got grant=%0d want %0d", n, grant_id, n % 4);
            end
            serve(n % 4, 16, oc, xc, de, fo);
            checks++;
            if (oc != 16 || xc != 0 || de != 0 || !fo) begin
                failures++;
                $display("FAIL rr_beats burst=%0d got own=%0d other=%0d data_err=%0d fin=%0b want 16/0/0/1", n, oc, xc, de, fo);
            end
            checks++;
            if (busy !== 1'b0 || rd_burst_req !== 1'b0 || wr_burst_req !== 1'b0) begin
                failures++;
                $display("FAIL rr_idle_gap burst=%0d got busy=%0b rd=%0b wr=%0b want 0", n, busy, rd_burst_req, wr_burst_req);
            end
        end
        pend = 4'b0;
        drive_reqs();
        tick();
    endtask

    task automatic test_c1_write();
        int oc, xc, de;
        bit fo;
        do_reset();
        pend        = 4'b1000;
        req_len[3]  = BB'(128);
        req_addr[3] = 24'h001000;
        drive_reqs();
        tick();
        $display("c1 write: grant=%0d wr=%0b len=%0d addr=%h", grant_id, wr_burst_req, wr_burst_len, wr_burst_addr);
        checks++;
        if (wr_burst_req !== 1'b1 || rd_burst_req !== 1'b0 || grant_id !== 2'd3) begin
            failures++;
            $display("FAIL c1wr_grant got wr=%0b rd=%0b grant=%0d want 1/0/3", wr_burst_req, rd_burst_req, grant_id);
        end
        checks++;
        if (wr_burst_addr !== 24'h001000 || wr_burst_len !== BB'(128)) begin
            failures++;
            $display("FAIL c1wr_lenaddr got len=%0d addr=%h want 128/001000", wr_burst_len, wr_burst_addr);
        end
        serve(3, 128, oc, xc, de, fo);
        checks++;
        if (oc != 128 || xc != 0) begin
            failures++;
            $display("FAIL c1wr_datareq got own=%0d other=%0d want 128/0", oc, xc);
        end
        checks++;
        if (de != 0 || !fo) begin
            failures++;
            $display("FAIL c1wr_data got data_err=%0d fin=%0b want 0/1", de, fo);
        end
        pend = 4'b0;
        drive_reqs();
        tick();
    endtask

    task automatic test_spurious_finish();
        int oc, xc, de;
        bit fo;
        do_reset();
        pend        = 4'b0001;
        req_len[0]  = BB'(8);
        req_addr[0] = AB'($urandom);
        drive_reqs();
        tick();
        pend = 4'b0;
        drive_reqs();
        $display("spurious: grant=%0d rd=%0b", grant_id, rd_burst_req);
        wr_burst_finish   = 1'b1;
        wr_burst_data_req = 1'b1;
        #1;
        checks++;
        if (c_wr_burst_finish !== 2'b00 || c_wr_burst_data_req !== 2'b00) begin
            failures++;
            $display("FAIL spur_steer got wr_fin=%b wr_dreq=%b want 00/00", c_wr_burst_finish, c_wr_burst_data_req);
        end
        tick();
        wr_burst_finish   = 1'b0;
        wr_burst_data_req = 1'b0;
        checks++;
        if (busy !== 1'b1 || rd_burst_req !== 1'b1 || grant_id !== 2'd0 || rd_burst_len !== BB'(8)) begin
            failures++;
            $display("FAIL spur_hold got busy=%0b rd=%0b grant=%0d len=%0d want 1/1/0/8", busy, rd_burst_req, grant_id, rd_burst_len);
        end
        serve(0, 8, oc, xc, de, fo);
        checks++;
        if (oc != 8 || xc != 0 || de != 0 || !fo) begin
            failures++;
            $display("FAIL spur_burst got own=%0d other=%0d data_err=%0d fin=%0b want 8/0/0/1", oc, xc, de, fo);
        end
        rd_burst_data_valid = 1'b1;
        rd_burst_finish     = 1'b1;
        #1;
        checks++;
        if (c_rd_burst_data_valid !== 2'b00 || c_rd_burst_finish !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_strobe got dv=%b fin=%b busy=%0b want 00/00/0", c_rd_burst_data_valid, c_rd_burst_finish, busy);
        end
        tick();
        rd_burst_data_valid = 1'b0;
        rd_burst_finish     = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int oc, xc, de, exp;
        bit fo;
        do_reset();
        pend        = 4'b0100;
        req_len[2]  = BB'(16);
        req_addr[2] = AB'($urandom);
        drive_reqs();
        tick();
        checks++;
        if (grant_id !== 2'd2 || rd_burst_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_grant got grant=%0d rd=%0b want 2/1", grant_id, rd_burst_req);
        end
        for (int b = 0; b < 5; b++) begin
            rd_burst_data_valid = 1'b1;
            tick();
            rd_burst_data_valid = 1'b0;
        end
        rd_burst_data_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        $display("mid-burst reset: rd=%0b wr=%0b busy=%0b", rd_burst_req, wr_burst_req, busy);
        checks++;
        if (rd_burst_req !== 1'b0 || wr_burst_req !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL mid_async got rd=%0b wr=%0b busy=%0b grant=%0d want 0/0/0/0", rd_burst_req, wr_burst_req, busy, grant_id);
        end
        checks++;
        if (rd_burst_len !== '0 || rd_burst_addr !== '0 || c_rd_burst_data_valid !== 2'b00) begin
            failures++;
            $display("FAIL mid_clear got len=%0d addr=%h dv=%b want 0/0/00", rd_burst_len, rd_burst_addr, c_rd_burst_data_valid);
        end
        rd_burst_data_valid = 1'b0;
        tick();
        rst  = 1'b0;
        pend = 4'b1000 | 4'($urandom_range(1, 7));
        for (int k = 0; k < 4; k++) begin
            req_len[k]  = BB'($urandom_range(1, 6));
            req_addr[k] = AB'($urandom);
        end
        drive_reqs();
        tick();
        exp = lowest(pend);
        $display("post-reset grant: pend=%b grant=%0d", pend, grant_id);
        checks++;
        if (grant_id !== 2'(exp) || !(rd_burst_req || wr_burst_req)) begin
            failures++;
            $display("FAIL mid_first_grant got grant=%0d req=%0b want %0d/1", grant_id, rd_burst_req | wr_burst_req, exp);
        end
        pend = 4'b0;
        drive_reqs();
        serve(exp, int'(req_len[exp]), oc, xc, de, fo);
        checks++;
        if (oc != int'(req_len[exp]) || xc != 0 || !fo) begin
            failures++;
            $display("FAIL mid_post_burst got own=%0d other=%0d fin=%0b want %0d/0/1", oc, xc, fo, req_len[exp]);
        end
        tick();
    endtask

    task automatic test_drop_after_finish();
        int oc, xc, de;
        bit fo;
        do_reset();
        pend        = 4'b0001;
        req_len[0]  = BB'(4);
        req_addr[0] = AB'($urandom);
        drive_reqs();
        tick();
        serve(0, 4, oc, xc, de, fo);
        pend = 4'b0;
        drive_reqs();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || rd_burst_req !== 1'b0 || wr_burst_req !== 1'b0) begin
                failures++;
                $display("FAIL drop_no_regrant cycle=%0d got busy=%0b rd=%0b wr=%0b want 0", c, busy, rd_burst_req, wr_burst_req);
            end
        end
        do_reset();
        pend = 4'b1001;
        req_len[0]  = BB'(3);
        req_len[3]  = BB'(5);
        req_addr[0] = AB'($urandom);
        req_addr[3] = AB'($urandom);
        drive_reqs();
        tick();
        checks++;
        if (grant_id !== 2'd0 || rd_burst_req !== 1'b1) begin
            failures++;
            $display("FAIL drop_first got grant=%0d rd=%0b want 0/1", grant_id, rd_burst_req);
        end
        serve(0, 3, oc, xc, de, fo);
        pend[0] = 1'b0;
        drive_reqs();
        tick();
        $display("drop: next grant=%0d wr=%0b addr=%h", grant_id, wr_burst_req, wr_burst_addr);
        checks++;
        if (grant_id !== 2'd3 || wr_burst_req !== 1'b1 || rd_burst_req !== 1'b0 || wr_burst_addr !== req_addr[3]) begin
            failures++;
            $display("FAIL drop_next got grant=%0d wr=%0b rd=%0b addr=%h want 3/1/0/%h", grant_id, wr_burst_req, rd_burst_req, wr_burst_addr, req_addr[3]);
        end
        pend = 4'b0;
        drive_reqs();
        serve(3, 5, oc, xc, de, fo);
        tick();
    endtask

    task automatic test_c1_read();
        int oc, xc, de, len;
        bit fo;
        do_reset();
        len         = $urandom_range(1, 64);
        pend        = 4'b0100;
        req_len[2]  = BB'(len);
        req_addr[2] = AB'($urandom);
        drive_reqs();
        tick();
        $display("c1 read: grant=%0d len=%0d addr=%h", grant_id, rd_burst_len, rd_burst_addr);
        checks++;
        if (grant_id !== 2'd2 || rd_burst_len !== BB'(len) || rd_burst_addr !== req_addr[2]) begin
            failures++;
            $display("FAIL c1rd_grant got grant=%0d len=%0d addr=%h want 2/%0d/%h", grant_id, rd_burst_len, rd_burst_addr, len, req_addr[2]);
        end
        pend = 4'b0;
        drive_reqs();
        serve(2, len, oc, xc, de, fo);
        checks++;
        if (oc != len || xc != 0 || de != 0 || !fo) begin
            failures++;
            $display("FAIL c1rd_beats got own=%0d other=%0d data_err=%0d fin=%0b want %0d/0/0/1", oc, xc, de, fo, len);
        end
        tick();
    endtask

    task automatic test_random();
        bit got;
        bit fo;
        int exp, oc, xc, de;
        bit [3:0] add;
        do_reset();
        ptr_m = 0;
        for (int n = 0; n < 14; n++) begin
            if (pend == 4'b0) begin
                pend = 4'($urandom_range(1, 15));
                for (int k = 0; k < 4; k++) begin
                    if (pend[k]) begin
                        req_len[k]  = BB'($urandom_range(1, 8));
                        req_addr[k] = AB'($urandom);
                    end
                end
            end
            drive_reqs();
            tick();
            checks++;
            if (!(rd_burst_req || wr_burst_req)) begin
                failures++;
                $display("FAIL rand_latency burst=%0d got no request want request", n);
                await_req(got);
                if (!got) return;
            end
            exp   = pick(pend, ptr_m);
            ptr_m = (exp + 1) % 4;
            $display("rand burst %0d: pend=%b grant=%0d rd=%0b wr=%0b", n, pend, grant_id, rd_burst_req, wr_burst_req);
            checks++;
            if (grant_id !== 2'(exp) || {wr_burst_req, rd_burst_req} !== ((exp % 2 == 1) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL rand_grant burst=%0d got grant=%0d wr=%0b rd=%0b want %0d", n, grant_id, wr_burst_req, rd_burst_req, exp);
            end
            checks++;
            if (((exp % 2 == 1) ? {wr_burst_len, wr_burst_addr} : {rd_burst_len, rd_burst_addr}) !== {req_len[exp], req_addr[exp]}) begin
                failures++;
                $display("FAIL rand_lenaddr burst=%0d got rd %0d/%h wr %0d/%h want %0d/%h", n, rd_burst_len, rd_burst_addr, wr_burst_len, wr_burst_addr, req_len[exp], req_addr[exp]);
            end
            serve(exp, int'(req_len[exp]), oc, xc, de, fo);
            checks++;
            if (oc != int'(req_len[exp]) || xc != 0 || de != 0 || !fo) begin
                failures++;
                $display("FAIL rand_beats burst=%0d got own=%0d other=%0d data_err=%0d fin=%0b want %0d/0/0/1", n, oc, xc, de, fo, req_len[exp]);
            end
            checks++;
            if (busy !== 1'b0 || rd_burst_req !== 1'b0 || wr_burst_req !== 1'b0) begin
                failures++;
                $display("FAIL rand_release burst=%0d got busy=%0b rd=%0b wr=%0b want 0", n, busy, rd_burst_req, wr_burst_req);
            end
            pend[exp] = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                add = 4'($urandom) & ~pend;
                for (int k = 0; k < 4; k++) begin
                    if (add[k]) begin
                        req_len[k]  = BB'($urandom_range(1, 8));
                        req_addr[k] = AB'($urandom);
                    end
                end
                pend = pend | add;
            end
        end
        pend = 4'b0;
        drive_reqs();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want $finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_c1_write();
        test_spurious_finish();
        test_reset_mid_burst();
        test_drop_after_finish();
        test_c1_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
